// File: rtl/pe_input_reader_pkg.sv
// -----------------------------------------------------------------------------
// pe_input_reader_pkg
// Shared I/O-window constants for the memory-mapped peripherals that sit in
// the 0xFFFF_Fxxx region (display port and input reader), plus the read-select
// decode used by the input reader.
// Contents:
//   DISP_ADDR, SW_ADDR, BTN_ADDR, EVT_ADDR  12-bit offsets inside the window
//   IO_INTERVAL                             sample/scan tick period minus 1
//   rd_sel_e, decode_addr()                 address to read-source decode
// -----------------------------------------------------------------------------
package pe_input_reader_pkg;

   localparam logic [11:0] DISP_ADDR = 12'h000;
   localparam logic [11:0] SW_ADDR   = 12'h070;
   localparam logic [11:0] BTN_ADDR  = 12'h078;
   localparam logic [11:0] EVT_ADDR  = 12'h07C;

   // 2 ms at 50 MHz; also drives the display scan counter.
   localparam int IO_INTERVAL = 99999;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_SW   = 2'd1,
      RD_BTN  = 2'd2,
      RD_EVT  = 2'd3
   } rd_sel_e;

   function automatic rd_sel_e decode_addr(input logic [11:0] a);
      rd_sel_e sel;
      case (a)
         SW_ADDR:  sel = RD_SW;
         BTN_ADDR: sel = RD_BTN;
         EVT_ADDR: sel = RD_EVT;
         default:  sel = RD_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/pe_input_reader_debounce.sv
// -----------------------------------------------------------------------------
// pe_debounce
// Tick-sampled debouncer for a W-bit vector sharing one counter. A new level
// is accepted only after it differs from the committed level on DEB_SAMPLES
// consecutive ticks; any tick where the input matches restarts the count.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  asynchronous, active-high reset
//   tick  in  1  sample strobe, one cycle wide
//   din   in  W  synchronised input
//   dout  out W  debounced (committed) level
// -----------------------------------------------------------------------------
module pe_debounce #(
   parameter int W           = 1,
   parameter int DEB_SAMPLES = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int CW = $clog2(DEB_SAMPLES);

   logic [W-1:0]  r_stable;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stable <= '0;
         r_cnt    <= '0;
      end else if (tick) begin
         if (din == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_SAMPLES - 1)) begin
            // Commit the whole vector as sampled on this tick.
            r_stable <= din;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign dout = r_stable;

endmodule

// File: rtl/pe_input_reader.sv
// -----------------------------------------------------------------------------
// pe_input_reader
// CPU-readable input peripheral: synchronises and debounces 24 slide switches
// and 5 push buttons, and presents switch level, button level and sticky
// button-press events on the CPU load path (registered, 1-cycle latency).
// Ports:
//   clk    in   1   system clock
//   rst    in   1   asynchronous, active-high reset
//   addr   in   12  CPU address bits [11:0]
//   ren    in   1   CPU read enable
//   sw     in   24  raw slide switches (asynchronous)
//   btn    in   5   raw push buttons (asynchronous)
//   rdata  out  32  registered read data
// -----------------------------------------------------------------------------
module pe_input_reader
   import pe_input_reader_pkg::*;
#(
   parameter int INTERVAL    = IO_INTERVAL,
   parameter int DEB_SAMPLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] addr,
   input  logic        ren,
   input  logic [23:0] sw,
   input  logic [4:0]  btn,
   output logic [31:0] rdata
);

   localparam int TW = $clog2(INTERVAL + 1);

   logic [23:0]   r_sw_s1, r_sw_s2;
   logic [4:0]    r_btn_s1, r_btn_s2;
   logic [TW-1:0] r_tick_cnt;
   logic [4:0]    r_btn_prev;
   logic [4:0]    r_evt;
   logic [31:0]   r_rdata;

   logic          w_tick;
   logic [23:0]   w_sw_stable;
   logic [4:0]    w_btn_stable;
   logic [4:0]    w_press;
   rd_sel_e       w_rd_sel;

   // Two-flop synchronisers; only the second stage is used downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_btn_s1 <= '0;
         r_btn_s2 <= '0;
      end else begin
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
         r_btn_s1 <= btn;
         r_btn_s2 <= r_btn_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   assign w_tick = (r_tick_cnt == TW'(INTERVAL));

   pe_debounce #(
      .W           (24),
      .DEB_SAMPLES (DEB_SAMPLES)
   ) u_sw_deb (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick),
      .din  (r_sw_s2),
      .dout (w_sw_stable)
   );

   for (genvar g = 0; g < 5; g++) begin : g_btn_deb
      pe_debounce #(
         .W           (1),
         .DEB_SAMPLES (DEB_SAMPLES)
      ) u_btn_deb (
         .clk  (clk),
         .rst  (rst),
         .tick (w_tick),
         .din  (r_btn_s2[g]),
         .dout (w_btn_stable[g])
      );
   end

   // Both prev and stable clear on reset, so reset release never looks like a press.
   assign w_press  = w_btn_stable & ~r_btn_prev;
   assign w_rd_sel = ren ? decode_addr(addr) : RD_NONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn_prev <= '0;
         r_evt      <= '0;
         r_rdata    <= '0;
      end else begin
         r_btn_prev <= w_btn_stable;
         case (w_rd_sel)
            RD_SW:   r_rdata <= {8'h0, w_sw_stable};
            RD_BTN:  r_rdata <= {27'h0, w_btn_stable};
            RD_EVT:  r_rdata <= {27'h0, r_evt};
            default: r_rdata <= '0;
         endcase
         // Read-clear and a new press on the same edge: the set wins, the
         // reader sees the old value and the press is reported next read.
         r_evt <= ((w_rd_sel == RD_EVT) ? 5'h0 : r_evt) | w_press;
      end
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_pe_input_reader.sv
// -----------------------------------------------------------------------------
// tb_pe_input_reader
// Self-checking bench for pe_input_reader with INTERVAL=4, DEB_SAMPLES=3
// (tick every 5 clocks, a new level is accepted after 3 ticks).
// -----------------------------------------------------------------------------
module tb_pe_input_reader;

   logic        clk;
   logic        rst;
   logic [11:0] addr;
   logic        ren;
   logic [23:0] sw;
   logic [4:0]  btn;
   logic [31:0] rdata;

   int n_vec;
   int n_err;

   logic [31:0] sb[$];

   typedef struct {
      logic [11:0] a;
      logic        r;
      logic [31:0] e;
      string       nm;
   } vec_t;

   vec_t tbl[8];

   pe_input_reader #(
      .INTERVAL    (4),
      .DEB_SAMPLES (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .addr  (addr),
      .ren   (ren),
      .sw    (sw),
      .btn   (btn),
      .rdata (rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; drives one read cycle and checks it at the next negedge.
   task automatic rd(input logic [11:0] a, input logic r, input logic [31:0] e, input string nm);
      logic [31:0] exp;
      addr = a;
      ren  = r;
      sb.push_back(e);
      @(negedge clk);
      ren  = 1'b0;
      addr = 12'h0;
      exp  = sb.pop_front();
      check(nm, rdata, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int          hits;
      logic [31:0] hitval;

      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      addr  = 12'h0;
      ren   = 1'b0;
      sw    = 24'h0;
      btn   = 5'h0;

      // 1: reset state
      wait_clk(2);
      check("reset_rdata", rdata, 32'h0);
      rst = 1'b0;
      rd(12'h070, 1'b1, 32'h0, "rst_sw");
      rd(12'h078, 1'b1, 32'h0, "rst_btn");
      rd(12'h07C, 1'b1, 32'h0, "rst_evt");

      // 2: switches
      sw = 24'hA5C3F0;
      wait_clk(20);
      rd(12'h070, 1'b1, 32'h00A5C3F0, "sw_level");

      // 6: decode table in steady state (sw committed, no buttons)
      tbl[0] = '{12'h070, 1'b1, 32'h00A5C3F0, "dec_sw"};
      tbl[1] = '{12'h074, 1'b1, 32'h0,        "dec_074"};
      tbl[2] = '{12'h070, 1'b1, 32'h00A5C3F0, "dec_sw2"};
      tbl[3] = '{12'h000, 1'b1, 32'h0,        "dec_000"};
      tbl[4] = '{12'h070, 1'b0, 32'h0,        "dec_ren0"};
      tbl[5] = '{12'hF70, 1'b1, 32'h0,        "dec_F70"};
      tbl[6] = '{12'h078, 1'b1, 32'h0,        "dec_btn"};
      tbl[7] = '{12'h07C, 1'b1, 32'h0,        "dec_evt"};
      for (int i = 0; i < 8; i++) rd(tbl[i].a, tbl[i].r, tbl[i].e, tbl[i].nm);

      // 3: glitch shorter than the debounce window
      btn[2] = 1'b1;
      wait_clk(7);
      btn[2] = 1'b0;
      wait_clk(20);
      rd(12'h078, 1'b1, 32'h0, "glitch_btn");
      rd(12'h07C, 1'b1, 32'h0, "glitch_evt");

      // 4: press event on btn[0]
      btn[0] = 1'b1;
      wait_clk(25);
      rd(12'h078, 1'b1, 32'h1, "held_btn");
      wait_clk(4);
      btn[0] = 1'b0;
      wait_clk(25);
      rd(12'h074, 1'b1, 32'h0, "evt_keep_074");
      rd(12'h000, 1'b1, 32'h0, "evt_keep_000");
      rd(12'h070, 1'b0, 32'h0, "evt_keep_ren0");
      rd(12'h078, 1'b1, 32'h0, "released_btn");
      rd(12'h07C, 1'b1, 32'h1, "press_evt");
      rd(12'h07C, 1'b1, 32'h0, "press_evt_cleared");

      // 5: continuous EVT reads across the btn[4] commit; the press must be
      // reported exactly once even though a read lands on the set edge.
      hits   = 0;
      hitval = 32'h0;
      btn[4] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         addr = 12'h07C;
         ren  = 1'b1;
         @(negedge clk);
         if (rdata != 32'h0) begin
            hits++;
            hitval = rdata;
         end
      end
      ren  = 1'b0;
      addr = 12'h0;
      check("collision_hits", 32'(hits), 32'h1);
      check("collision_val", hitval, 32'h10);
      rd(12'h07C, 1'b1, 32'h0, "collision_after");
      btn[4] = 1'b0;
      wait_clk(25);
      rd(12'h07C, 1'b1, 32'h0, "release_no_evt");
      rd(12'h078, 1'b1, 32'h0, "release_btn");

      // Asynchronous reset mid-cycle, with a button mid-debounce
      btn[1] = 1'b1;
      wait_clk(8);
      addr = 12'h070;
      ren  = 1'b1;
      @(posedge clk);
      #1;
      check("pre_reset_rd", rdata, 32'h00A5C3F0);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", rdata, 32'h0);
      ren    = 1'b0;
      addr   = 12'h0;
      btn[1] = 1'b0;
      wait_clk(2);
      rst = 1'b0;
      rd(12'h070, 1'b1, 32'h0, "post_reset_sw");
      wait_clk(25);
      rd(12'h07C, 1'b1, 32'h0, "post_reset_evt");
      rd(12'h070, 1'b1, 32'h00A5C3F0, "post_reset_sw_back");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
